// File: rtl/humandet_blob_tx.sv
// humandet_blob_tx: streams one frame of NBEAT activation words from RAM into the
// human-detection post processor (init pulse, then NBEAT o_we/o_dout beats).
module humandet_blob_tx #(
    parameter int NUM_LAYER = 4,
    parameter int ADDR_W    = 12,
    parameter int GAP       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              i_hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              o_init,
    output logic              o_we,
    output logic [15:0]       o_dout,
    output logic              busy,
    output logic              done
);
    localparam int NBEAT = (NUM_LAYER == 4) ? 384 : 96;

    typedef enum logic [2:0] {IDLE, INIT, READ, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [11:0]       idx;
    logic [3:0]        gap_cnt;
    logic [ADDR_W-1:0] base;
    logic              we_d1;
    logic              last;

    assign last    = idx == 12'(NBEAT - 1);
    assign rd_en   = state == READ && !i_hold && gap_cnt == 4'd0;
    assign rd_addr = rd_en ? base + ADDR_W'(idx) : '0;
    assign o_init  = state == INIT;
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? INIT : IDLE;
            INIT:    state_nx = READ;
            READ:    state_nx = (rd_en && last) ? DRAIN : READ;
            // the last beat leaves the pipe when o_we is up and nothing follows it
            DRAIN:   state_nx = (o_we && !we_d1) ? DONE : DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            base    <= '0;
            we_d1   <= 1'b0;
            o_we    <= 1'b0;
            o_dout  <= '0;
        end else begin
            state <= state_nx;
            we_d1 <= rd_en;
            o_we  <= we_d1;
            if (we_d1)
                o_dout <= rd_data;
            if (state == IDLE && start) begin
                base    <= base_addr;
                idx     <= '0;
                gap_cnt <= '0;
            end else if (rd_en) begin
                idx     <= idx + 12'd1;
                gap_cnt <= 4'(GAP);
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end
endmodule
